// File: rtl/ovf_fifo_push_sched_if.sv
// Push/pop/flush bundle between producer stages, the consumer and the overflow-FIFO scheduler.
interface ovf_fifo_push_sched_if #(
    parameter int NREQ  = 4,
    parameter int DW    = 16,
    parameter int CAP   = 3,
    parameter int CNT_W = 8
);
    localparam int OCC_W = $clog2(CAP + 1);

    logic [NREQ-1:0]         req;
    logic [NREQ-1:0][DW-1:0] req_data;
    logic [NREQ-1:0]         gnt;
    logic                    flush_req;
    logic                    drain_req;
    logic                    drain_done;
    logic                    cons_pop;
    logic                    fifo_push;
    logic [DW-1:0]           fifo_data;
    logic                    fifo_pop;
    logic                    fifo_flush;
    logic [OCC_W-1:0]        occ;
    logic                    ovf_evt;
    logic [CNT_W-1:0]        ovf_cnt;

    // master: requesters/consumer side; slave: the scheduler
    modport master (
        output req, req_data, flush_req, drain_req, cons_pop,
        input  gnt, drain_done, fifo_push, fifo_data, fifo_pop, fifo_flush,
               occ, ovf_evt, ovf_cnt
    );

    modport slave (
        input  req, req_data, flush_req, drain_req, cons_pop,
        output gnt, drain_done, fifo_push, fifo_data, fifo_pop, fifo_flush,
               occ, ovf_evt, ovf_cnt
    );
endinterface

// File: rtl/ovf_fifo_push_sched.sv
// Round-robin arbiter for a shared overflow-FIFO push port, with pop/flush/drain sequencing,
// a cycle-exact occupancy mirror and a saturating overwrite counter.
module ovf_fifo_push_sched #(
    parameter int NREQ      = 4,
    parameter int DW        = 16,
    parameter int CAP       = 3,
    parameter int ALLOW_OVF = 1,
    parameter int CNT_W     = 8
) (
    input logic clk,
    input logic rst,
    ovf_fifo_push_sched_if.slave bus
);
    localparam int OCC_W = $clog2(CAP + 1);
    localparam int RR_W  = $clog2(NREQ);
    localparam logic [OCC_W-1:0] CAP_V  = OCC_W'(CAP);
    localparam logic [RR_W-1:0]  LAST_V = RR_W'(NREQ - 1);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t            state;
    logic [RR_W-1:0]   rr;
    logic [OCC_W-1:0]  occ_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              done_q;

    logic [NREQ-1:0]   gnt;
    logic [RR_W-1:0]   win;
    logic              hit;
    logic              elig;
    logic              push;
    logic              pop;
    logic              ovf;
    int                idx;

    // All combinational outputs are forced low while reset is asserted.
    always_comb begin
        pop  = ~rst & bus.cons_pop & (occ_q != '0) & ~bus.flush_req;
        elig = ~rst & (state == RUN) & ~bus.flush_req &
               ((ALLOW_OVF != 0) | (occ_q < CAP_V) | pop);
        hit  = 1'b0;
        win  = '0;
        idx  = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr) + k) % NREQ;
            if (!hit && bus.req[idx]) begin
                hit = 1'b1;
                win = RR_W'(idx);
            end
        end
        gnt = '0;
        if (elig && hit) gnt[win] = 1'b1;
        push = |gnt;
        // A push into a full FIFO without a matching pop drops the oldest entry.
        ovf  = (ALLOW_OVF != 0) & push & ~pop & (occ_q == CAP_V);
    end

    assign bus.gnt        = gnt;
    assign bus.fifo_push  = push;
    assign bus.fifo_data  = push ? bus.req_data[win] : '0;
    assign bus.fifo_pop   = pop;
    assign bus.fifo_flush = ~rst & bus.flush_req;
    assign bus.occ        = occ_q;
    assign bus.ovf_evt    = ovf;
    assign bus.ovf_cnt    = cnt_q;
    assign bus.drain_done = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            rr     <= '0;
            occ_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // ovf is already low in a flush cycle, so the count survives flushes.
            if (ovf && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            if (bus.flush_req) begin
                state <= RUN;
                rr    <= '0;
                occ_q <= '0;
            end else begin
                if (push) rr <= (win == LAST_V) ? '0 : win + RR_W'(1);
                if (push && !pop && occ_q != CAP_V) occ_q <= occ_q + OCC_W'(1);
                else if (!push && pop)              occ_q <= occ_q - OCC_W'(1);
                case (state)
                    RUN:   if (bus.drain_req) state <= DRAIN;
                    DRAIN: if (occ_q == '0) begin
                        state  <= RUN;
                        done_q <= 1'b1;
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ovf_fifo_push_sched.sv
// Bench: three scheduler builds (overwrite, no-overwrite, 2-bit counter) on one shared stimulus.
module tb_ovf_fifo_push_sched;
    logic clk;
    logic rst;
    logic [3:0]       req;
    logic [3:0][15:0] req_data;
    logic             flush_req, drain_req, cons_pop;

    int ncmp = 0;
    int nerr = 0;
    int dcnt = 0;
    logic [15:0] sbq[$];

    ovf_fifo_push_sched_if #(.NREQ(4), .DW(16), .CAP(3), .CNT_W(8)) ia();
    ovf_fifo_push_sched_if #(.NREQ(4), .DW(16), .CAP(3), .CNT_W(8)) ib();
    ovf_fifo_push_sched_if #(.NREQ(4), .DW(16), .CAP(3), .CNT_W(2)) ic();

    assign ia.req = req; assign ia.req_data = req_data; assign ia.flush_req = flush_req;
    assign ia.drain_req = drain_req; assign ia.cons_pop = cons_pop;
    assign ib.req = req; assign ib.req_data = req_data; assign ib.flush_req = flush_req;
    assign ib.drain_req = drain_req; assign ib.cons_pop = cons_pop;
    assign ic.req = req; assign ic.req_data = req_data; assign ic.flush_req = flush_req;
    assign ic.drain_req = drain_req; assign ic.cons_pop = cons_pop;

    ovf_fifo_push_sched #(.NREQ(4), .DW(16), .CAP(3), .ALLOW_OVF(1), .CNT_W(8))
        dut_a (.clk(clk), .rst(rst), .bus(ia));
    ovf_fifo_push_sched #(.NREQ(4), .DW(16), .CAP(3), .ALLOW_OVF(0), .CNT_W(8))
        dut_b (.clk(clk), .rst(rst), .bus(ib));
    ovf_fifo_push_sched #(.NREQ(4), .DW(16), .CAP(3), .ALLOW_OVF(1), .CNT_W(2))
        dut_c (.clk(clk), .rst(rst), .bus(ic));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       pop, drn, fl;
        logic [3:0] gnt;
        logic       fpop, ovf;
        logic [1:0] occ;
        logic [7:0] cnt;
        logic       done;
    } vec_t;

    vec_t tv[23];

    function automatic vec_t mk(logic [3:0] r, logic p, logic d, logic f, logic [3:0] g,
                                logic fp, logic ov, logic [1:0] o, logic [7:0] c, logic dn);
        vec_t v;
        v.req = r; v.pop = p; v.drn = d; v.fl = f; v.gnt = g;
        v.fpop = fp; v.ovf = ov; v.occ = o; v.cnt = c; v.done = dn;
        return v;
    endfunction

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, id, act, exp);
        end
    endtask

    // Inputs change on the falling edge; combinational outputs are sampled 1ns later.
    task automatic drive(input logic [3:0] r, input logic p, input logic d, input logic f);
        @(negedge clk);
        req = r; cons_pop = p; drain_req = d; flush_req = f;
        for (int i = 0; i < 4; i++) req_data[i] = {4'(i + 1), 12'(dcnt)};
        dcnt++;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            req     pop drn fl  gnt     fpop ovf occ cnt done
        tv[0]  = mk(4'b1111, 0, 0, 0, 4'b0001, 0, 0, 1, 0, 0);
        tv[1]  = mk(4'b1111, 0, 0, 0, 4'b0010, 0, 0, 2, 0, 0);
        tv[2]  = mk(4'b1111, 0, 0, 0, 4'b0100, 0, 0, 3, 0, 0);
        tv[3]  = mk(4'b1111, 0, 0, 0, 4'b1000, 0, 1, 3, 1, 0);
        tv[4]  = mk(4'b0000, 1, 0, 0, 4'b0000, 1, 0, 2, 1, 0);
        tv[5]  = mk(4'b0001, 1, 0, 0, 4'b0001, 1, 0, 2, 1, 0);
        tv[6]  = mk(4'b0001, 0, 0, 0, 4'b0001, 0, 0, 3, 1, 0);
        tv[7]  = mk(4'b0011, 0, 0, 0, 4'b0010, 0, 1, 3, 2, 0);
        tv[8]  = mk(4'b0000, 1, 0, 0, 4'b0000, 1, 0, 2, 2, 0);
        tv[9]  = mk(4'b0011, 1, 1, 0, 4'b0001, 1, 0, 2, 2, 0);
        tv[10] = mk(4'b0011, 1, 0, 0, 4'b0000, 1, 0, 1, 2, 0);
        tv[11] = mk(4'b0011, 1, 0, 0, 4'b0000, 1, 0, 0, 2, 0);
        tv[12] = mk(4'b0011, 1, 0, 0, 4'b0000, 0, 0, 0, 2, 1);
        tv[13] = mk(4'b0011, 0, 0, 0, 4'b0010, 0, 0, 1, 2, 0);
        tv[14] = mk(4'b0000, 1, 0, 0, 4'b0000, 1, 0, 0, 2, 0);
        tv[15] = mk(4'b0000, 1, 0, 0, 4'b0000, 0, 0, 0, 2, 0);
        tv[16] = mk(4'b0000, 0, 1, 0, 4'b0000, 0, 0, 0, 2, 0);
        tv[17] = mk(4'b0001, 0, 0, 0, 4'b0000, 0, 0, 0, 2, 1);
        tv[18] = mk(4'b0001, 0, 0, 0, 4'b0001, 0, 0, 1, 2, 0);
        tv[19] = mk(4'b1111, 0, 0, 0, 4'b0010, 0, 0, 2, 2, 0);
        tv[20] = mk(4'b1111, 0, 0, 0, 4'b0100, 0, 0, 3, 2, 0);
        tv[21] = mk(4'b1000, 1, 1, 1, 4'b0000, 0, 0, 0, 2, 0);
        tv[22] = mk(4'b1001, 0, 0, 0, 4'b0001, 0, 0, 1, 2, 0);

        // Reset with every input active: outputs must stay quiet.
        rst = 1'b1; req = 4'b1111; cons_pop = 1'b1; flush_req = 1'b1; drain_req = 1'b1;
        for (int i = 0; i < 4; i++) req_data[i] = 16'hFFFF;
        #7;
        chk("rst_gnt", 0, ia.gnt, 0);
        chk("rst_push", 0, ia.fifo_push, 0);
        chk("rst_pop", 0, ia.fifo_pop, 0);
        chk("rst_flush", 0, ia.fifo_flush, 0);
        chk("rst_occ", 0, ia.occ, 0);
        chk("rst_cnt", 0, ia.ovf_cnt, 0);
        chk("rst_done", 0, ia.drain_done, 0);
        req = '0; cons_pop = 1'b0; flush_req = 1'b0; drain_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 23; v++) begin
            drive(tv[v].req, tv[v].pop, tv[v].drn, tv[v].fl);
            for (int i = 0; i < 4; i++)
                if (tv[v].gnt[i]) sbq.push_back(req_data[i]);
            chk("gnt", v, ia.gnt, tv[v].gnt);
            chk("push", v, ia.fifo_push, |tv[v].gnt);
            chk("fifo_pop", v, ia.fifo_pop, tv[v].fpop);
            chk("ovf_evt", v, ia.ovf_evt, tv[v].ovf);
            chk("fifo_flush", v, ia.fifo_flush, tv[v].fl);
            if (ia.fifo_push) begin
                if (sbq.size() == 0) chk("sb_underrun", v, 1, 0);
                else chk("fifo_data", v, ia.fifo_data, sbq.pop_front());
            end
            tick();
            chk("occ", v, ia.occ, tv[v].occ);
            chk("ovf_cnt", v, ia.ovf_cnt, tv[v].cnt);
            chk("drain_done", v, ia.drain_done, tv[v].done);
        end
        chk("sb_left", 0, sbq.size(), 0);

        // No-overwrite build: grants withheld while full unless a pop frees a slot.
        @(negedge clk);
        req = '0; cons_pop = 1'b0; flush_req = 1'b0; drain_req = 1'b0;
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(4'b0001, 0, 0, 0);
            chk("b_fill_gnt", k, ib.gnt, 4'b0001);
            tick();
        end
        chk("b_occ_full", 0, ib.occ, 3);
        drive(4'b0001, 0, 0, 0);
        chk("b_full_gnt", 0, ib.gnt, 0);
        chk("b_full_ovf", 0, ib.ovf_evt, 0);
        chk("a_full_gnt", 0, ia.gnt, 4'b0001);
        chk("a_full_ovf", 0, ia.ovf_evt, 1);
        tick();
        chk("b_occ_hold", 0, ib.occ, 3);
        drive(4'b0001, 1, 0, 0);
        chk("b_pop_gnt", 0, ib.gnt, 4'b0001);
        chk("b_pop_fpop", 0, ib.fifo_pop, 1);
        tick();
        chk("b_occ_pop", 0, ib.occ, 3);

        // Saturation on the 2-bit counter build; the 8-bit build keeps counting.
        for (int k = 1; k <= 5; k++) begin
            drive(4'b1111, 0, 0, 0);
            tick();
            chk("c_cnt_sat", k, ic.ovf_cnt, (k + 1 > 3) ? 3 : k + 1);
        end
        chk("a_cnt6", 0, ia.ovf_cnt, 6);

        // Reset asserted mid-drain clears everything immediately.
        drive(4'b0000, 1, 0, 0);
        tick();
        chk("a_occ2", 0, ia.occ, 2);
        drive(4'b0000, 0, 1, 0);
        tick();
        drive(4'b0011, 0, 0, 0);
        chk("a_drain_gnt", 0, ia.gnt, 0);
        #1 rst = 1'b1;
        #1;
        chk("arst_occ", 0, ia.occ, 0);
        chk("arst_cnt", 0, ia.ovf_cnt, 0);
        chk("arst_gnt", 0, ia.gnt, 0);
        chk("arst_push", 0, ia.fifo_push, 0);
        chk("arst_done", 0, ia.drain_done, 0);
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        drive(4'b0001, 0, 0, 0);
        chk("arst_run_gnt", 0, ia.gnt, 4'b0001);
        tick();
        chk("arst_run_occ", 0, ia.occ, 1);

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end
endmodule
